// File: rtl/bf_uart_pkg.sv
// Shared types and constants for the brainfuck UART output stage.
package bf_uart_pkg;

    // Transmit FSM states, in frame order.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/bf_uart_tx_if.sv
// Byte handshake between the brainfuck core (master) and the UART stage (slave).
interface bf_uart_tx_if;
    import bf_uart_pkg::*;

    logic [DATA_BITS-1:0] output_data;
    logic                 output_write;
    logic                 output_busy;

    modport master (output output_data, output output_write, input output_busy);
    modport slave  (input output_data, input output_write, output output_busy);

endinterface

// File: rtl/bf_sync_fifo.sv
// Small synchronous FIFO. The head entry is presented on dout so the consumer
// can load it in the same cycle it pops.
module bf_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              w_push_ok;
    logic              w_pop_ok;

    // Full/empty come from registered occupancy only, so a pop in the same
    // cycle never makes room for a push.
    assign full      = (r_count == (ADDR_W+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~empty;
    assign dout      = r_mem[r_rd_ptr];

    // Storage write; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap modulo the depth; occupancy tracks push/pop balance.
    always_ff @(posedge clk) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bf_uart_tx.sv
// UART 8N1 transmitter fed from a FIFO; replaces the simulation-only byte sink.
module bf_uart_tx
    import bf_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 174,
    parameter int FIFO_AW      = 4
) (
    input  logic         clk,
    input  logic         rst_i,
    bf_uart_tx_if.slave  core,
    output logic         tx,
    output logic         tx_active,
    output logic         overflow
);
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

    tx_state_t            r_state, w_state_next;
    logic [BAUD_W-1:0]    r_baud, w_baud_next;
    logic [2:0]           r_bit_idx, w_bit_idx_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic                 r_tx, r_tx_active, r_overflow;
    logic                 w_tx_level;
    logic                 w_pop;
    logic                 w_baud_last;
    logic                 w_fifo_full, w_fifo_empty;
    logic [DATA_BITS-1:0] w_fifo_head;

    bf_sync_fifo #(
        .DATA_W (DATA_BITS),
        .ADDR_W (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_i (rst_i),
        .push  (core.output_write),
        .pop   (w_pop),
        .din   (core.output_data),
        .dout  (w_fifo_head),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    assign core.output_busy = w_fifo_full;
    assign w_baud_last      = (r_baud == BAUD_LAST);
    assign tx               = r_tx;
    assign tx_active        = r_tx_active;
    assign overflow         = r_overflow;

    // Next-state, baud/bit counters, shift register and line level for the current state.
    always_comb begin
        w_state_next   = r_state;
        w_baud_next    = w_baud_last ? '0 : r_baud + 1'b1;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_pop          = 1'b0;
        w_tx_level     = LINE_IDLE;
        case (r_state)
            ST_IDLE: begin
                w_baud_next = '0;
                if (!w_fifo_empty) begin
                    w_pop          = 1'b1;
                    w_shift_next   = w_fifo_head;
                    w_bit_idx_next = '0;
                    w_state_next   = ST_START;
                end
            end
            ST_START: begin
                w_tx_level = LINE_START;
                if (w_baud_last) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                w_tx_level = r_shift[0];
                if (w_baud_last) begin
                    w_shift_next   = r_shift >> 1;
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == BIT_LAST) w_state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                w_tx_level = LINE_IDLE;
                if (w_baud_last) begin
                    // Chain straight into the next start bit when more data waits.
                    if (!w_fifo_empty) begin
                        w_pop          = 1'b1;
                        w_shift_next   = w_fifo_head;
                        w_bit_idx_next = '0;
                        w_state_next   = ST_START;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State and datapath registers; tx and tx_active lag the state by one clock so both are glitch-free flops.
    always_ff @(posedge clk) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_baud      <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_tx        <= LINE_IDLE;
            r_tx_active <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_baud      <= w_baud_next;
            r_bit_idx   <= w_bit_idx_next;
            r_shift     <= w_shift_next;
            r_tx        <= w_tx_level;
            r_tx_active <= (r_state != ST_IDLE);
            if (core.output_write && w_fifo_full) r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bf_uart_tx.sv
// Self-checking bench for bf_uart_tx: frame-level model, per-cycle compare, UART receiver.
module tb_bf_uart_tx;
    localparam int C     = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_i;
    logic tx, tx_active, overflow;

    bf_uart_tx_if u_if ();

    bf_uart_tx #(.CLKS_PER_BIT(C), .FIFO_AW(AW)) dut (
        .clk       (clk),
        .rst_i     (rst_i),
        .core      (u_if.slave),
        .tx        (tx),
        .tx_active (tx_active),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // FIFO is a queue of bytes; the line is a queue of per-clock levels that
    // each popped byte expands into (start, 8 data LSB first, stop; C clocks each).
    logic [7:0] fq[$];
    bit         line[$];
    int         frame_left = 0;
    bit         m_tx = 1'b1, m_act = 1'b0, m_ovf = 1'b0, m_busy = 1'b0;
    int         rst_count = 0;
    bit         m_push, m_pop;
    logic [7:0] m_byte;

    always @(posedge clk) begin
        if (!rst_i) begin
            fq.delete();
            line.delete();
            frame_left = 0;
            m_tx = 1'b1; m_act = 1'b0; m_ovf = 1'b0; m_busy = 1'b0;
            rst_count++;
        end else begin
            m_push = u_if.output_write && (fq.size() < DEPTH);
            if (u_if.output_write && fq.size() == DEPTH) m_ovf = 1'b1;
            m_pop = 1'b0;
            if (frame_left > 0) begin
                frame_left--;
                if (frame_left == 0 && fq.size() > 0) m_pop = 1'b1;
            end else if (fq.size() > 0) begin
                m_pop = 1'b1;
            end
            if (line.size() > 0) begin
                m_tx = line.pop_front();
                m_act = 1'b1;
            end else begin
                m_tx = 1'b1;
                m_act = 1'b0;
            end
            if (m_pop) begin
                m_byte = fq.pop_front();
                frame_left = 10 * C;
                for (int k = 0; k < C; k++) line.push_back(1'b0);
                for (int i = 0; i < 8; i++)
                    for (int k = 0; k < C; k++) line.push_back(m_byte[i]);
                for (int k = 0; k < C; k++) line.push_back(1'b1);
            end
            if (m_push) fq.push_back(u_if.output_data);
            m_busy = (fq.size() == DEPTH);
        end
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx", tx, m_tx);
            chk("tx_active", tx_active, m_act);
            chk("output_busy", u_if.output_busy, m_busy);
            chk("overflow", overflow, m_ovf);
        end
    end

    // ---------------- independent UART receiver ----------------
    logic [7:0] rx_q[$];
    int         rx_starts[$];
    bit         rx_busy = 1'b0;
    int         rx_start = 0;
    int         rx_rst_seen = 0;
    logic [7:0] rx_byte;
    int         run = 0, last_run = 0;

    always @(negedge clk) begin
        int off, b;
        if (tx_active === 1'b1) run++;
        else if (run > 0) begin last_run = run; run = 0; end
        if (rx_rst_seen != rst_count) begin
            rx_busy = 1'b0;
            rx_rst_seen = rst_count;
        end else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy = 1'b1; rx_start = cyc; rx_byte = '0;
                rx_starts.push_back(cyc);
            end
        end else begin
            off = cyc - rx_start;
            if (off % C == C / 2) begin
                b = off / C;
                if (b >= 1 && b <= 8) rx_byte[b-1] = tx;
                if (b == 9) begin
                    chk("stop_bit", tx, 1'b1);
                    rx_q.push_back(rx_byte);
                    $display("rx byte %02h at cycle %0d", rx_byte, cyc);
                    rx_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int last_set = 0;

    task automatic drive(input logic w, input logic [7:0] d);
        @(negedge clk);
        u_if.output_write = w;
        u_if.output_data  = d;
        last_set = cyc;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (tx_active === 1'b0 && fq.size() == 0 && line.size() == 0 && !rx_busy) done = 1'b1;
        end
        if (!done) begin
            bad++; total++;
            $display("FAIL %s: timeout got busy expected idle within %0d cycles", name, budget);
        end
        @(negedge clk);
    endtask

    task automatic check_rx(input string name, input logic [7:0] exp[$]);
        chk({name, "_count"}, rx_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_byte%0d", name, i), rx_q[i], exp[i]);
    endtask

    initial begin
        int c0;
        rst_i = 1'b0;
        u_if.output_write = 1'b0;
        u_if.output_data  = '0;

        // Reset
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        chk_en = 1'b1;
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", u_if.output_busy, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_active", tx_active, 1'b0);
        $display("reset done");

        // Single byte 0x48
        rx_q.delete(); rx_starts.delete();
        drive(1'b1, 8'h48);
        c0 = last_set;
        drive(1'b0, 8'h00);
        wait_idle("single", 100);
        check_rx("single", '{8'h48});
        if (rx_starts.size() > 0) chk("single_latency", rx_starts[0] - (c0 + 1), 2);
        else chk("single_latency", 0, 2);
        chk("single_len", last_run, 40);

        // Burst 0x01..0x05 then overflow write 0xAA while full
        rx_q.delete();
        for (int i = 1; i <= 5; i++) drive(1'b1, 8'(i));
        @(negedge clk);
        chk("burst_busy", u_if.output_busy, 1'b1);
        chk("burst_ovf", overflow, 1'b0);
        u_if.output_write = 1'b1;
        u_if.output_data  = 8'hAA;
        drive(1'b0, 8'h00);
        chk("ovf_set", overflow, 1'b1);
        wait_idle("burst", 400);
        check_rx("burst", '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
        chk("burst_len", last_run, 200);
        chk("ovf_sticky", overflow, 1'b1);

        // Reset mid-frame during 0x55, then 0x0F
        rx_q.delete();
        drive(1'b1, 8'h55);
        drive(1'b0, 8'h00);
        for (int i = 0; i < 50 && tx_active !== 1'b1; i++) @(negedge clk);
        repeat (4 * C) @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        chk("midrst_tx", tx, 1'b1);
        chk("midrst_active", tx_active, 1'b0);
        chk("midrst_ovf", overflow, 1'b0);
        chk("midrst_busy", u_if.output_busy, 1'b0);
        repeat (60) @(negedge clk);
        chk("midrst_nofr", rx_q.size(), 0);
        drive(1'b1, 8'h0F);
        drive(1'b0, 8'h00);
        wait_idle("after_rst", 100);
        check_rx("after_rst", '{8'h0F});

        // Push and pop together at a frame boundary
        rx_q.delete();
        drive(1'b1, 8'hA1);
        c0 = last_set;
        drive(1'b1, 8'hA2);
        drive(1'b1, 8'hA3);
        drive(1'b0, 8'h00);
        while (cyc < c0 + 41) @(negedge clk);
        u_if.output_write = 1'b1;
        u_if.output_data  = 8'hA4;
        @(negedge clk);
        u_if.output_write = 1'b0;
        chk("pushpop_occ", 32'(dut.u_fifo.r_count), 2);
        wait_idle("pushpop", 300);
        check_rx("pushpop", '{8'hA1, 8'hA2, 8'hA3, 8'hA4});
        chk("pushpop_len", last_run, 160);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
